// File: rtl/plab5_mcore_mem_responder.sv
// plab5_mcore_mem_responder
// Memory-side responder for one cache port. It accepts a single cacheline
// request and waits p_latency extra cycles. It then presents the response,
// holding it stable under backpressure. A write lands in the line array only
// when the response handshake completes, so a request dropped by reset never
// touches the array. The array itself has no reset and keeps its contents.

module plab5_mcore_mem_responder #(
    parameter int  p_mem_nbytes   = 1024,
    parameter int  p_latency      = 2,
    localparam int c_opaque_nbits = 8,
    localparam int c_addr_nbits   = 32,
    localparam int c_line_nbits   = 128,
    localparam int c_req_nbits    = 3 + c_opaque_nbits + c_addr_nbits + 4 + c_line_nbits,
    localparam int c_resp_nbits   = 3 + c_opaque_nbits + 2 + 4 + c_line_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_req_nbits-1:0]  memreq_msg,
    input  logic                    memreq_val,
    output logic                    memreq_rdy,
    output logic [c_resp_nbits-1:0] memresp_msg,
    output logic                    memresp_val,
    input  logic                    memresp_rdy,
    output logic                    busy
);

    localparam int c_idx_top    = $clog2(p_mem_nbytes) - 1;
    localparam int c_idx_nbits  = c_idx_top - 3;
    localparam int c_nlines     = p_mem_nbytes / 16;
    localparam logic [31:0] c_latency = p_latency;

    localparam logic [2:0] c_type_read       = 3'd0;
    localparam logic [2:0] c_type_write      = 3'd1;
    localparam logic [2:0] c_type_write_init = 3'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_RESP = 2'd2
    } state_t;

    // Merge the low len bytes of new_data into old_line; len of 0 means a full line.
    function automatic logic [c_line_nbits-1:0] merge_line(
        input logic [c_line_nbits-1:0] old_line,
        input logic [c_line_nbits-1:0] new_data,
        input logic [3:0]              len
    );
        logic [c_line_nbits-1:0] result;
        result = old_line;
        for (int i = 0; i < 16; i++) begin
            if ((len == 4'd0) || (i < int'(len))) begin
                result[8*i +: 8] = new_data[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_line[8*i +: 8];
            end
        end
        return result;
    endfunction

    // WRITE and WRITE_INIT both store into the array.
    function automatic logic is_write(input logic [2:0] msg_type);
        return (msg_type == c_type_write) || (msg_type == c_type_write_init);
    endfunction

    // Request fields as they arrive on the port.
    logic [2:0]              in_type_s;
    logic [7:0]              in_opaque_s;
    logic [31:0]             in_addr_s;
    logic [3:0]              in_len_s;
    logic [c_line_nbits-1:0] in_data_s;

    assign in_type_s   = memreq_msg[c_req_nbits-1 -: 3];
    assign in_opaque_s = memreq_msg[c_req_nbits-4 -: 8];
    assign in_addr_s   = memreq_msg[c_line_nbits+4 +: 32];
    assign in_len_s    = memreq_msg[c_line_nbits +: 4];
    assign in_data_s   = memreq_msg[c_line_nbits-1:0];

    // Address bits outside the line index are ignored.
    logic unused_s;
    assign unused_s = ^{in_addr_s[31:c_idx_top+1], in_addr_s[3:0]};

    state_t                  state_r;
    state_t                  next_state_s;
    logic [31:0]             cnt_r;
    logic [2:0]              type_r;
    logic [7:0]              opaque_r;
    logic [c_idx_nbits-1:0]  idx_r;
    logic [3:0]              len_r;
    logic [c_line_nbits-1:0] data_r;
    logic                    req_rdy_r;
    logic                    resp_val_r;
    logic                    busy_r;
    logic [c_resp_nbits-1:0] resp_msg_r;
    logic [c_line_nbits-1:0] mem_r [0:c_nlines-1];

    logic                    req_go_s;
    logic                    resp_go_s;
    logic                    resp_enter_s;
    logic [2:0]              src_type_s;
    logic [7:0]              src_opaque_s;
    logic [c_idx_nbits-1:0]  src_idx_s;
    logic [3:0]              src_len_s;
    logic [c_line_nbits-1:0] src_rdata_s;
    logic [c_resp_nbits-1:0] resp_build_s;

    assign req_go_s     = memreq_val && req_rdy_r;
    assign resp_go_s    = resp_val_r && memresp_rdy;
    assign resp_enter_s = (next_state_s == STATE_RESP) && (state_r != STATE_RESP);

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            STATE_IDLE: begin
                if (req_go_s) begin
                    next_state_s = (c_latency == 32'd0) ? STATE_RESP : STATE_WAIT;
                end else begin
                    next_state_s = STATE_IDLE;
                end
            end
            STATE_WAIT: begin
                if (cnt_r <= 32'd1) begin
                    next_state_s = STATE_RESP;
                end else begin
                    next_state_s = STATE_WAIT;
                end
            end
            STATE_RESP: begin
                if (resp_go_s) begin
                    next_state_s = STATE_IDLE;
                end else begin
                    next_state_s = STATE_RESP;
                end
            end
            default: begin
                next_state_s = STATE_IDLE;
            end
        endcase
    end

    // Source of the response: with zero latency RESP is entered straight from IDLE, so use the live request.
    always_comb begin
        src_type_s   = type_r;
        src_opaque_s = opaque_r;
        src_idx_s    = idx_r;
        src_len_s    = len_r;
        if (state_r == STATE_IDLE) begin
            src_type_s   = in_type_s;
            src_opaque_s = in_opaque_s;
            src_idx_s    = in_addr_s[c_idx_top:4];
            src_len_s    = in_len_s;
        end else begin
            src_type_s   = type_r;
            src_opaque_s = opaque_r;
            src_idx_s    = idx_r;
            src_len_s    = len_r;
        end
        if (src_type_s == c_type_read) begin
            src_rdata_s = mem_r[src_idx_s];
        end else begin
            src_rdata_s = '0;
        end
        resp_build_s = {src_type_s, src_opaque_s, 2'b00, src_len_s, src_rdata_s};
    end

    // FSM state, latency counter, captured request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= STATE_IDLE;
            cnt_r      <= 32'd0;
            type_r     <= 3'd0;
            opaque_r   <= 8'd0;
            idx_r      <= '0;
            len_r      <= 4'd0;
            data_r     <= '0;
            req_rdy_r  <= 1'b0;
            resp_val_r <= 1'b0;
            busy_r     <= 1'b0;
            resp_msg_r <= '0;
        end else begin
            state_r    <= next_state_s;
            req_rdy_r  <= (next_state_s == STATE_IDLE);
            resp_val_r <= (next_state_s == STATE_RESP);
            busy_r     <= (next_state_s != STATE_IDLE);
            if (req_go_s) begin
                type_r   <= in_type_s;
                opaque_r <= in_opaque_s;
                idx_r    <= in_addr_s[c_idx_top:4];
                len_r    <= in_len_s;
                data_r   <= in_data_s;
                cnt_r    <= c_latency;
            end else if (state_r == STATE_WAIT) begin
                cnt_r <= cnt_r - 32'd1;
            end
            if (resp_enter_s) begin
                resp_msg_r <= resp_build_s;
            end else if (resp_go_s) begin
                resp_msg_r <= '0;
            end
        end
    end

    // Line array: a write commits only on the response handshake.
    always_ff @(posedge clk) begin
        if (resp_go_s && is_write(type_r)) begin
            mem_r[idx_r] <= merge_line(mem_r[idx_r], data_r, len_r);
        end
    end

    assign memreq_rdy  = req_rdy_r;
    assign memresp_val = resp_val_r;
    assign memresp_msg = resp_msg_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_plab5_mcore_mem_responder.sv
// Directed bench for plab5_mcore_mem_responder: one instance with latency 2,
// one with latency 0, sharing clock and reset.

module tb_plab5_mcore_mem_responder;

    logic clk;
    logic reset;

    logic [174:0] req_msg2,  req_msg0;
    logic         req_val2,  req_val0;
    logic         req_rdy2,  req_rdy0;
    logic [144:0] resp_msg2, resp_msg0;
    logic         resp_val2, resp_val0;
    logic         resp_rdy2, resp_rdy0;
    logic         busy2,     busy0;

    int n_checks;
    int n_pass;

    plab5_mcore_mem_responder #(.p_mem_nbytes(1024), .p_latency(2)) dut2 (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg2), .memreq_val(req_val2), .memreq_rdy(req_rdy2),
        .memresp_msg(resp_msg2), .memresp_val(resp_val2), .memresp_rdy(resp_rdy2),
        .busy(busy2)
    );

    plab5_mcore_mem_responder #(.p_mem_nbytes(1024), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg0), .memreq_val(req_val0), .memreq_rdy(req_rdy0),
        .memresp_msg(resp_msg0), .memresp_val(resp_val0), .memresp_rdy(resp_rdy0),
        .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   t;
        logic [7:0]   op;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs [13];
    vec_t seq0 [4];

    task automatic chk(input string name, input logic [144:0] act, input logic [144:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [144:0] exp_resp(input vec_t v);
        return {v.t, v.op, 2'b00, v.len, v.exp_data};
    endfunction

    // One request on dut2; returns the response and posedges from accept to valid.
    task automatic run2(input vec_t v, output logic [144:0] msg, output int lat);
        int n;
        msg = '0;
        lat = -1;
        n = 0;
        while (!req_rdy2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_msg2 = {v.t, v.op, v.addr, v.len, v.data};
        req_val2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_val2 = 1'b0;
        req_msg2 = '0;
        n = 1;
        while (!resp_val2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (resp_val2) begin
            lat = n;
            msg = resp_msg2;
        end
        if (resp_rdy2) begin
            @(negedge clk);
        end
    endtask

    logic [144:0] got;
    logic [144:0] held;
    int           lat;
    vec_t         v;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        req_msg2 = '0; req_val2 = 1'b0; resp_rdy2 = 1'b1;
        req_msg0 = '0; req_val0 = 1'b0; resp_rdy0 = 1'b1;

        vecs[0]  = '{3'd1, 8'h01, 32'h40,  4'd0,  128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 128'h0};
        vecs[1]  = '{3'd0, 8'h5A, 32'h40,  4'd0,  128'h0, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
        vecs[2]  = '{3'd1, 8'h02, 32'h80,  4'd0,  {128{1'b1}}, 128'h0};
        vecs[3]  = '{3'd1, 8'h03, 32'h80,  4'd4,  128'h1111_2222_3333_4444_5555_6666_AABB_CCDD, 128'h0};
        vecs[4]  = '{3'd0, 8'h04, 32'h80,  4'd0,  128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_AABB_CCDD};
        vecs[5]  = '{3'd2, 8'h05, 32'h400, 4'd0,  128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_0246_8ACE, 128'h0};
        vecs[6]  = '{3'd0, 8'h06, 32'h0,   4'd0,  128'h0, 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_0246_8ACE};
        vecs[7]  = '{3'd0, 8'h07, 32'h44C, 4'd0,  128'h0, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
        vecs[8]  = '{3'd1, 8'h08, 32'h10,  4'd0,  128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 128'h0};
        vecs[9]  = '{3'd5, 8'h09, 32'h10,  4'd7,  {128{1'b1}}, 128'h0};
        vecs[10] = '{3'd1, 8'h0A, 32'hC0,  4'd0,  128'h0, 128'h0};
        vecs[11] = '{3'd1, 8'h0B, 32'hC0,  4'd15, {16{8'hAB}}, 128'h0};
        vecs[12] = '{3'd0, 8'h0C, 32'hC0,  4'd0,  128'h0, 128'h00AB_ABAB_ABAB_ABAB_ABAB_ABAB_ABAB_ABAB};

        seq0[0] = '{3'd1, 8'h21, 32'h20, 4'd0, 128'h5555_AAAA_1234_5678_9ABC_DEF0_0F1E_2D3C, 128'h0};
        seq0[1] = '{3'd0, 8'h22, 32'h20, 4'd0, 128'h0, 128'h5555_AAAA_1234_5678_9ABC_DEF0_0F1E_2D3C};
        seq0[2] = '{3'd5, 8'h77, 32'h0,  4'd3, {128{1'b1}}, 128'h0};
        seq0[3] = '{3'd0, 8'h23, 32'h20, 4'd0, 128'h0, 128'h5555_AAAA_1234_5678_9ABC_DEF0_0F1E_2D3C};

        // Reset state: outputs forced low while reset is held.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_req_rdy2",  145'(req_rdy2),  145'd0);
        chk("rst_resp_val2", 145'(resp_val2), 145'd0);
        chk("rst_busy2",     145'(busy2),     145'd0);
        chk("rst_resp_msg2", resp_msg2,       145'd0);
        chk("rst_req_rdy0",  145'(req_rdy0),  145'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rdy_low_before_edge", 145'(req_rdy2), 145'd0);
        @(negedge clk);
        chk("rdy_after_first_edge", 145'(req_rdy2), 145'd1);

        // Table-driven transactions on the latency-2 instance.
        for (int i = 0; i < 13; i++) begin
            run2(vecs[i], got, lat);
            chk($sformatf("vec%0d_msg", i), got, exp_resp(vecs[i]));
            chk($sformatf("vec%0d_lat", i), 145'(lat), 145'd3);
        end

        // Backpressure: response held for 5 cycles with memresp_rdy low.
        resp_rdy2 = 1'b0;
        run2(vecs[1], held, lat);
        chk("bp_first_msg", held, exp_resp(vecs[1]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_val_c%0d", k), 145'(resp_val2), 145'd1);
            chk($sformatf("bp_msg_c%0d", k), resp_msg2, held);
            chk($sformatf("bp_rdy_c%0d", k), 145'(req_rdy2), 145'd0);
        end
        resp_rdy2 = 1'b1;
        @(negedge clk);
        chk("bp_val_after", 145'(resp_val2), 145'd0);
        chk("bp_idle_rdy",  145'(req_rdy2),  145'd1);
        chk("bp_idle_busy", 145'(busy2),     145'd0);

        // Reset mid-WAIT of a write to 0x10: dropped, array untouched.
        req_msg2 = {3'd1, 8'h31, 32'h10, 4'd0, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000};
        req_val2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_val2 = 1'b0;
        req_msg2 = '0;
        chk("mid_wait_busy", 145'(busy2), 145'd1);
        reset = 1'b0;
        #1;
        chk("midrst_resp_val", 145'(resp_val2), 145'd0);
        chk("midrst_busy",     145'(busy2),     145'd0);
        chk("midrst_req_rdy",  145'(req_rdy2),  145'd0);
        @(negedge clk);
        reset = 1'b1;
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_val2) lat++;
        end
        chk("midrst_no_resp", 145'(lat), 145'd0);
        v = '{3'd0, 8'h32, 32'h10, 4'd0, 128'h0, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100};
        run2(v, got, lat);
        chk("midrst_read_old", got, exp_resp(v));

        // Zero latency, back-to-back valid: accept and response alternate.
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                req_msg0 = {seq0[k/2].t, seq0[k/2].op, seq0[k/2].addr, seq0[k/2].len, seq0[k/2].data};
                req_val0 = 1'b1;
                chk($sformatf("b2b_rdy_c%0d", k), 145'(req_rdy0),  145'd1);
                chk($sformatf("b2b_val_c%0d", k), 145'(resp_val0), 145'd0);
            end else begin
                chk($sformatf("b2b_rdy_c%0d", k), 145'(req_rdy0),  145'd0);
                chk($sformatf("b2b_val_c%0d", k), 145'(resp_val0), 145'd1);
                chk($sformatf("b2b_msg_c%0d", k), resp_msg0, exp_resp(seq0[k/2]));
            end
            @(negedge clk);
        end
        req_val0 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
